strive_hkspi: RTL and testbench

- Housekeeping SPI slave of the striVe chip.
- Gives an external host byte-stream read/write access to a small register file: ID registers, PLL control, IRQ and external-reset request.
- SPI pins are oversampled in the core clock domain, so all logic runs on one clock.
- Sits between the chip's CSB/SCK/SDI/SDO pads and the PLL, reset and IRQ logic.

---
 rtl/strive_hkspi_pkg.sv | 61 ++++++
 rtl/hkspi_sync_edge.sv | 38 +++
 rtl/strive_hkspi.sv | 184 ++++++++++++++++++
 tb/tb_strive_hkspi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/strive_hkspi_pkg.sv
// Shared definitions for the striVe housekeeping SPI slave: command codes,
// register addresses, FSM state and transfer-mode encodings.
// Optional build macro: HKSPI_RDWR_EN enables the 0xC0 read-write stream.
package strive_hkspi_pkg;

    // Command byte values
    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_RDWR  = 8'hC0;

    // Register map addresses
    localparam logic [7:0] ADDR_RSVD     = 8'd0;
    localparam logic [7:0] ADDR_MFGR_HI  = 8'd1;
    localparam logic [7:0] ADDR_MFGR_LO  = 8'd2;
    localparam logic [7:0] ADDR_PROD     = 8'd3;
    localparam logic [7:0] ADDR_PLL_CTRL = 8'd4;
    localparam logic [7:0] ADDR_PLL_BYP  = 8'd5;
    localparam logic [7:0] ADDR_IRQ      = 8'd6;
    localparam logic [7:0] ADDR_EXT_RST  = 8'd7;
    localparam logic [7:0] ADDR_TRAP     = 8'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA
    } state_e;

    // What the DATA phase of the current frame does
    typedef enum logic [1:0] {
        MODE_NONE,
        MODE_READ,
        MODE_WRITE,
        MODE_RDWR
    } mode_e;

    function automatic mode_e decode_cmd(input logic [7:0] cmd);
        mode_e m;
        m = MODE_NONE;
        case (cmd)
            CMD_READ:  m = MODE_READ;
            CMD_WRITE: m = MODE_WRITE;
`ifdef HKSPI_RDWR_EN
            CMD_RDWR:  m = MODE_RDWR;
`else
            CMD_RDWR:  m = MODE_NONE;
`endif
            default:   m = MODE_NONE;
        endcase
        return m;
    endfunction

    function automatic logic mode_reads(input mode_e m);
        return (m == MODE_READ) || (m == MODE_RDWR);
    endfunction

    function automatic logic mode_writes(input mode_e m);
        return (m == MODE_WRITE) || (m == MODE_RDWR);
    endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Two-flop synchroniser for asynchronous pad inputs, followed by a delay
// stage that yields single-cycle rise/fall pulses of the synchronised value.
module hkspi_sync_edge #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] dly_q;

    // Synchroniser chain plus one delay stage for edge detection
    always_ff @(posedge clk_i) begin
        // NOTE: flops use non-blocking assignments so every stage samples the
        // previous stage's old value; blocking here would collapse the chain.
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            dly_q  <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/strive_hkspi.sv
// striVe housekeeping SPI slave (mode 0, pins oversampled on clk).
// Frame: command byte, address byte, then a stream of data bytes with
// auto-incrementing address. Build macro HKSPI_RDWR_EN adds the 0xC0
// read-write stream; without it 0xC0 is an unknown command.
module strive_hkspi
    import strive_hkspi_pkg::*;
#(
    parameter logic [11:0] MFGR_ID       = 12'h456,
    parameter logic [7:0]  PROD_ID       = 8'h05,
    parameter logic [7:0]  PLL_CTRL_INIT = 8'h07,
    parameter logic [7:0]  PLL_BYP_INIT  = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       csb,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic       trap,
    output logic [7:0] pll_ctrl,
    output logic       pll_bypass,
    output logic       irq_req,
    output logic       ext_reset
);

    logic sck_rise, sck_fall;
    logic csb_s, sdi_s;

    hkspi_sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (sck),
        .q_o     (),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // csb idles high so its synchroniser resets high
    hkspi_sync_edge #(.WIDTH(2), .RESET_VAL(2'b10)) u_sync_csb_sdi (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     ({csb, sdi}),
        .q_o     ({csb_s, sdi_s}),
        .rise_o  (),
        .fall_o  ()
    );

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] pll_ctrl_q, pll_ctrl_d;
    logic       pll_byp_q, pll_byp_d;
    logic       irq_q, irq_d;
    logic       ext_rst_q, ext_rst_d;

    logic [7:0] rx_byte;
    logic [7:0] rd_data;

    // Byte as it stands once the bit on the current sck rise is shifted in
    assign rx_byte = {rx_q, sdi_s};

    // Register file read mux
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            ADDR_RSVD:     rd_data = 8'h00;
            ADDR_MFGR_HI:  rd_data = {4'h0, MFGR_ID[11:8]};
            ADDR_MFGR_LO:  rd_data = MFGR_ID[7:0];
            ADDR_PROD:     rd_data = PROD_ID;
            ADDR_PLL_CTRL: rd_data = pll_ctrl_q;
            ADDR_PLL_BYP:  rd_data = {7'b0, pll_byp_q};
            ADDR_IRQ:      rd_data = {7'b0, irq_q};
            ADDR_EXT_RST:  rd_data = {7'b0, ext_rst_q};
            ADDR_TRAP:     rd_data = {7'b0, trap};
            default:       rd_data = 8'h00;
        endcase
    end

    // Frame FSM, bit shifting and register writes
    always_comb begin
        // NOTE: every next-state value defaults to its current value first so
        // no path through the branches below can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        pll_ctrl_d = pll_ctrl_q;
        pll_byp_d  = pll_byp_q;
        irq_d      = irq_q;
        ext_rst_d  = ext_rst_q;

        if (csb_s) begin
            // Deselected: abort the frame; a partial byte is simply dropped
            state_d   = ST_IDLE;
            mode_d    = MODE_NONE;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_CMD;
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        ST_CMD: begin
                            mode_d  = decode_cmd(rx_byte);
                            state_d = ST_ADDR;
                        end
                        ST_ADDR: begin
                            addr_d  = rx_byte;
                            state_d = ST_DATA;
                        end
                        ST_DATA: begin
                            if (mode_writes(mode_q)) begin
                                case (addr_q)
                                    ADDR_PLL_CTRL: pll_ctrl_d = rx_byte;
                                    ADDR_PLL_BYP:  pll_byp_d  = rx_byte[0];
                                    ADDR_IRQ:      irq_d      = rx_byte[0];
                                    ADDR_EXT_RST:  ext_rst_d  = rx_byte[0];
                                    default:       ;
                                endcase
                            end
                            addr_d = addr_q + 8'd1;
                        end
                        default: ;
                    endcase
                end
            end
            // On a byte boundary the fall loads the (already advanced) register;
            // otherwise it shifts the next bit out.
            if (sck_fall && (state_q == ST_DATA) && mode_reads(mode_q)) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_d = rd_data;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    // State and register file flops
    always_ff @(posedge clk) begin
        // NOTE: shift registers are reset along with control state so sdo is
        // defined immediately after reset, not just after the first frame.
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_NONE;
            bit_cnt_q  <= 3'd0;
            addr_q     <= 8'h00;
            rx_q       <= 7'h00;
            tx_q       <= 8'h00;
            pll_ctrl_q <= PLL_CTRL_INIT;
            pll_byp_q  <= PLL_BYP_INIT[0];
            irq_q      <= 1'b0;
            ext_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            pll_ctrl_q <= pll_ctrl_d;
            pll_byp_q  <= pll_byp_d;
            irq_q      <= irq_d;
            ext_rst_q  <= ext_rst_d;
        end
    end

    assign sdo_oe     = (state_q == ST_DATA) && mode_reads(mode_q);
    assign sdo        = sdo_oe & tx_q[7];
    assign pll_ctrl   = pll_ctrl_q;
    assign pll_bypass = pll_byp_q;
    assign irq_req    = irq_q;
    assign ext_reset  = ext_rst_q;

endmodule

// File: tb/tb_strive_hkspi.sv
// Self-checking bench for strive_hkspi: directed frames followed by random
// frames, compared against a register-map model of the slave.
module tb_strive_hkspi;

    localparam int HALF = 40;   // half SCK period; clk period is 10

    logic       clk = 1'b0;
    logic       reset, csb, sck, sdi, trap;
    logic       sdo, sdo_oe;
    logic [7:0] pll_ctrl;
    logic       pll_bypass, irq_req, ext_reset;

    int checks = 0;
    int errors = 0;

    // Model state of the writable registers
    logic [7:0] m_pll_ctrl;
    logic       m_byp, m_irq, m_ext;

    logic [7:0] wbuf [0:15];

    strive_hkspi dut (
        .clk        (clk),
        .reset      (reset),
        .csb        (csb),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .trap       (trap),
        .pll_ctrl   (pll_ctrl),
        .pll_bypass (pll_bypass),
        .irq_req    (irq_req),
        .ext_reset  (ext_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_reset();
        m_pll_ctrl = 8'h07;
        m_byp      = 1'b1;
        m_irq      = 1'b0;
        m_ext      = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'd1:    return 8'h04;
            8'd2:    return 8'h56;
            8'd3:    return 8'h05;
            8'd4:    return m_pll_ctrl;
            8'd5:    return {7'b0, m_byp};
            8'd6:    return {7'b0, m_irq};
            8'd7:    return {7'b0, m_ext};
            8'd8:    return {7'b0, trap};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'd4:    m_pll_ctrl = d;
            8'd5:    m_byp = d[0];
            8'd6:    m_irq = d[0];
            8'd7:    m_ext = d[0];
            default: ;
        endcase
    endtask

    function automatic logic m_reads(input logic [7:0] cmd);
`ifdef HKSPI_RDWR_EN
        return (cmd == 8'h40) || (cmd == 8'hC0);
`else
        return cmd == 8'h40;
`endif
    endfunction

    function automatic logic m_writes(input logic [7:0] cmd);
`ifdef HKSPI_RDWR_EN
        return (cmd == 8'h80) || (cmd == 8'hC0);
`else
        return cmd == 8'h80;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " pll_ctrl"},   pll_ctrl,   m_pll_ctrl);
        check({tag, " pll_bypass"}, pll_bypass, m_byp);
        check({tag, " irq_req"},    irq_req,    m_irq);
        check({tag, " ext_reset"},  ext_reset,  m_ext);
    endtask

    // ---------------- SPI host ----------------
    task automatic spi_begin();
        csb = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        csb = 1'b1;
        #(2 * HALF);
    endtask

    // Shift n bits MSB-first from v; sdo is captured on each rise
    task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sdi = v[i];
            #HALF;
            rx[i] = sdo;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] v, output logic [7:0] rx);
        spi_bits(v, 8, rx);
    endtask

    // Full frame: cmd, addr, n data bytes from wbuf; checks every byte
    task automatic frame(input logic [7:0] cmd, input logic [7:0] addr, input int n, input string tag);
        logic [7:0] rx;
        logic [7:0] a;
        logic [7:0] exp;
        a = addr;
        spi_begin();
        spi_byte(cmd, rx);
        spi_byte(addr, rx);
        for (int i = 0; i < n; i++) begin
            exp = m_reads(cmd) ? m_read(a) : 8'h00;
            spi_byte(wbuf[i], rx);
            check($sformatf("%s rd[%0d] a=%0h", tag, i, a), rx, exp);
            if (m_writes(cmd)) m_write(a, wbuf[i]);
            check_outputs($sformatf("%s byte%0d", tag, i));
            a = a + 8'd1;
        end
        check({tag, " sdo_oe in data"}, sdo_oe, m_reads(cmd));
        spi_end();
        check({tag, " sdo_oe idle"}, sdo_oe, 1'b0);
        check({tag, " sdo idle"}, sdo, 1'b0);
    endtask

    task automatic clear_wbuf();
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h00;
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] cmd, addr;
        int         n;

        reset = 1'b1;
        csb   = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        trap  = 1'b0;
        m_reset();
        clear_wbuf();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset sdo", sdo, 1'b0);
        check("reset sdo_oe", sdo_oe, 1'b0);
        check("reset pll_ctrl", pll_ctrl, 8'h07);
        check("reset pll_bypass", pll_bypass, 1'b1);
        check("reset irq_req", irq_req, 1'b0);
        check("reset ext_reset", ext_reset, 1'b0);

        // Single-byte read of product ID
        frame(8'h40, 8'h03, 1, "rd_prod");

        // Nine-byte stream from 0 with trap low
        frame(8'h40, 8'h00, 9, "rd_all");

        // ext_reset set, cleared, read back
        wbuf[0] = 8'h01;
        frame(8'h80, 8'h07, 1, "wr_ext1");
        check("ext_reset set", ext_reset, 1'b1);
        wbuf[0] = 8'h00;
        frame(8'h80, 8'h07, 1, "wr_ext0");
        frame(8'h40, 8'h07, 1, "rd_ext");

        // Writes to read-only registers are ignored
        wbuf[0] = 8'hFF; wbuf[1] = 8'h3C;
        frame(8'h80, 8'h02, 2, "wr_ro");
        clear_wbuf();
        frame(8'h40, 8'h02, 2, "rd_ro");
        wbuf[0] = 8'h02; wbuf[1] = 8'h00;
        frame(8'h80, 8'h04, 2, "wr_pll");
        check("pll_ctrl written", pll_ctrl, 8'h02);
        check("pll_bypass written", pll_bypass, 1'b0);
        clear_wbuf();
        frame(8'h40, 8'h04, 2, "rd_pll");

        // Partial byte discarded
        spi_begin();
        spi_byte(8'h80, rx);
        spi_byte(8'h06, rx);
        spi_bits(8'hFF, 4, rx);
        spi_end();
        check("partial irq_req", irq_req, 1'b0);
        frame(8'h40, 8'h06, 1, "rd_irq");

        // Address wrap 0xFF -> 0x00
        frame(8'h40, 8'hFF, 3, "rd_wrap");

        // Reset in the middle of a read
        wbuf[0] = 8'h33;
        frame(8'h80, 8'h04, 1, "wr_pll33");
        spi_begin();
        spi_byte(8'h40, rx);
        spi_byte(8'h04, rx);
        spi_bits(8'h00, 3, rx);
        check("midread sdo_oe", sdo_oe, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        m_reset();
        check("midreset sdo", sdo, 1'b0);
        check("midreset sdo_oe", sdo_oe, 1'b0);
        check_outputs("midreset");
        reset = 1'b0;
        csb   = 1'b1;
        #(2 * HALF);
        clear_wbuf();
        frame(8'h40, 8'h04, 1, "rd_after_reset");

        // Random frames
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0, 1:    cmd = 8'h40;
                2, 3:    cmd = 8'h80;
                4:       cmd = 8'hC0;
                default: begin
                    cmd = 8'($urandom_range(0, 255));
                    if (cmd == 8'h40 || cmd == 8'h80 || cmd == 8'hC0) cmd = 8'h11;
                end
            endcase
            if ($urandom_range(0, 3) == 0) addr = 8'hFC + 8'($urandom_range(0, 3));
            else                           addr = 8'($urandom_range(0, 11));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            trap = 1'($urandom_range(0, 1));
            frame(cmd, addr, n, $sformatf("rnd%0d c=%0h", t, cmd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
